// File: rtl/pipelined_cpa.sv
// pipelined_cpa: two-stage carry-propagate adder that resolves a carry-save
// pair (in_c, in_s) into out_sum = in_s + (in_c << 1). The carry chain is cut
// at LO_WIDTH, with one register between the two halves. A valid/ready
// handshake with full back-pressure runs on both sides.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready depends on out_ready)
//   in_c, in_s           carry vector (bit i weight 2^(i+1)), sum vector
//   out_valid/out_ready  output handshake (out_valid is registered)
//   out_sum              registered WIDTH+2 bit result
//   busy                 high while either stage holds a transaction
module pipelined_cpa #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned LO_WIDTH = WIDTH / 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_c,
   input  logic [WIDTH-1:0] in_s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH+1:0] out_sum,
   output logic             busy
);

   localparam int unsigned HI_X_W = WIDTH - LO_WIDTH;
   localparam int unsigned HI_Y_W = WIDTH + 1 - LO_WIDTH;
   localparam int unsigned HI_S_W = WIDTH + 2 - LO_WIDTH;

   // stage 1 state
   logic                v1_q;
   logic [LO_WIDTH-1:0] lo_q;
   logic                c1_q;
   logic [HI_X_W-1:0]   x_hi_q;
   logic [HI_Y_W-1:0]   y_hi_q;

   // stage 2 state
   logic                v2_q;
   logic [WIDTH+1:0]    sum_q;

   logic                adv2_c;
   logic                load1_c;
   logic [WIDTH:0]      y_c;
   logic [LO_WIDTH:0]   lo_c;
   logic [HI_S_W-1:0]   hi_c;

   // Carry vector aligned to its weight: Y = {in_c, 0}
   assign y_c = {in_c, 1'b0};

   // Low half resolved in stage 1, with its carry-out kept as the extra MSB
   assign lo_c = {1'b0, in_s[LO_WIDTH-1:0]} + {1'b0, y_c[LO_WIDTH-1:0]};

   // High half resolved in stage 2, absorbing the registered stage-1 carry
   assign hi_c = HI_S_W'(x_hi_q) + HI_S_W'(y_hi_q) + HI_S_W'(c1_q);

   // Stage 2 drains or is empty -> stage 1 may move forward
   assign adv2_c   = v1_q & (~v2_q | out_ready);
   assign in_ready = ~v1_q | adv2_c;
   assign load1_c  = in_valid & in_ready;

   // Pipeline registers
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         lo_q   <= '0;
         c1_q   <= 1'b0;
         x_hi_q <= '0;
         y_hi_q <= '0;
         v2_q   <= 1'b0;
         sum_q  <= '0;
      end else begin
         if (load1_c) begin
            v1_q   <= 1'b1;
            lo_q   <= lo_c[LO_WIDTH-1:0];
            c1_q   <= lo_c[LO_WIDTH];
            x_hi_q <= in_s[WIDTH-1:LO_WIDTH];
            y_hi_q <= y_c[WIDTH:LO_WIDTH];
         end else if (adv2_c) begin
            v1_q <= 1'b0;
         end

         if (adv2_c) begin
            v2_q  <= 1'b1;
            sum_q <= {hi_c, lo_q};
         end else if (out_ready) begin
            v2_q <= 1'b0;
         end
      end
   end

   assign out_valid = v2_q;
   assign out_sum   = sum_q;
   assign busy      = v1_q | v2_q;

endmodule
